// File: rtl/lfsr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_ctrl_pkg
// Shared definitions for the LFSR sequence controller family.
//   ctrl_state_t : controller FSM states (IDLE, RUN, DONE)
//   LFSR3_TAPS   : feedback mask for the 3-bit configuration (X^3+X^2+1)
//   LFSR3_SEED   : power-on seed for the 3-bit configuration (nonzero)
// ---------------------------------------------------------------------------
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_t;

  localparam logic [2:0] LFSR3_TAPS = 3'b011;
  localparam logic [2:0] LFSR3_SEED = 3'b011;

endpackage

// File: rtl/lfsr_step.sv
// ---------------------------------------------------------------------------
// lfsr_step
// Purely combinational next-state function of a Fibonacci LFSR.
// The feedback bit is the XOR of the state bits selected by TAPS and is
// shifted in at the MSB while the register shifts right.
// Ports:
//   cur : current LFSR state
//   nxt : state after one step
// ---------------------------------------------------------------------------
module lfsr_step #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 3'b011
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  logic fb;

  assign fb  = ^(cur & TAPS);
  assign nxt = {fb, cur[WIDTH-1:1]};

endmodule

// File: rtl/lfsr_sequence_controller.sv
// ---------------------------------------------------------------------------
// lfsr_sequence_controller
// Seeds an LFSR, runs it for a programmed number of handshaked words and
// measures the period of the sequence from the value held at run start.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   seed_load, seed     : load a nonzero seed while idle (zero -> seed_err)
//   start, length       : begin a run of 'length' words while idle
//   abort               : end a run early, no done pulse
//   out_valid/out_ready : word handshake, out_value is the LFSR state
//   busy                : high while running
//   done                : one-cycle pulse after the last word of a run
//   seed_err            : one-cycle pulse when a zero seed is rejected
//   period/period_valid : measured period for the last run
// ---------------------------------------------------------------------------
module lfsr_sequence_controller
  import lfsr_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 3,
  parameter logic [WIDTH-1:0] TAPS         = LFSR3_TAPS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR3_SEED,
  parameter int               COUNT_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  input  logic               start,
  input  logic [COUNT_W-1:0] length,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_value,
  output logic               busy,
  output logic               done,
  output logic               seed_err,
  output logic [COUNT_W-1:0] period,
  output logic               period_valid
);

  ctrl_state_t        state_reg;
  logic [WIDTH-1:0]   lfsr_reg;
  logic [WIDTH-1:0]   lfsr_next;
  logic [WIDTH-1:0]   snapshot_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic [COUNT_W-1:0] step_cnt_reg;
  logic               accept;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .cur (lfsr_reg),
    .nxt (lfsr_next)
  );

  assign out_value = lfsr_reg;
  // out_valid is only ever high in RUN, so the handshake implies RUN.
  assign accept    = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      lfsr_reg      <= DEFAULT_SEED;
      snapshot_reg  <= DEFAULT_SEED;
      remaining_reg <= '0;
      step_cnt_reg  <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      seed_err      <= 1'b0;
      period        <= '0;
      period_valid  <= 1'b0;
    end else begin
      done     <= 1'b0;
      seed_err <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // seed_load has priority over start in the same cycle
          if (seed_load) begin
            if (seed != '0) lfsr_reg <= seed;
            else            seed_err <= 1'b1;
          end else if (start && (length != '0)) begin
            state_reg     <= ST_RUN;
            out_valid     <= 1'b1;
            busy          <= 1'b1;
            remaining_reg <= length;
            snapshot_reg  <= lfsr_reg;
            step_cnt_reg  <= '0;
            period_valid  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            lfsr_reg      <= lfsr_next;
            remaining_reg <= remaining_reg - COUNT_W'(1);
            if (step_cnt_reg != '1) step_cnt_reg <= step_cnt_reg + COUNT_W'(1);
            // First return to the start value gives the period.
            if ((lfsr_next == snapshot_reg) && !period_valid) begin
              period       <= step_cnt_reg + COUNT_W'(1);
              period_valid <= 1'b1;
            end
          end
          // Abort wins over completion: an aborted run never pulses done.
          if (abort) begin
            state_reg <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (accept && (remaining_reg == COUNT_W'(1))) begin
            state_reg <= ST_DONE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lfsr_sequence_controller.md
Name: lfsr_sequence_controller

Overview:
- Sequences a Fibonacci LFSR of the codebase's shift/tap style.
- Seeds the register, runs it for a programmed number of steps, and emits one state per accepted valid/ready handshake.
- Measures the sequence period from the start value.
- Sits between a software/config front end and downstream consumers of pseudo-random words, e.g. test-pattern generators.

Parameters:
- WIDTH, 3, LFSR width in bits.
- TAPS, 3'b011, feedback mask; feedback bit = XOR of state bits where mask is 1. Default realises X^3+X^2+1.
- DEFAULT_SEED, 3'b011, LFSR value after reset; must be nonzero.
- COUNT_W, 8, width of the length, remaining and period counters.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- seed_load  in  1  load seed into LFSR (IDLE only).
- seed  in  WIDTH  seed value.
- start  in  1  begin a run (IDLE only).
- length  in  COUNT_W  number of words to emit in the run.
- abort  in  1  terminate the current run.
- out_valid  out  1  out_value holds a word.
- out_ready  in  1  consumer accepts the word.
- out_value  out  WIDTH  current LFSR state.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run completes normally.
- seed_err  out  1  one-cycle pulse when a zero seed is rejected.
- period  out  COUNT_W  measured period.
- period_valid  out  1  period holds a valid measurement for the last run.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; lfsr=DEFAULT_SEED.
  - out_valid=0, busy=0, done=0, seed_err=0, period=0, period_valid=0.
  - remaining=0, step_cnt=0.
  - out_value=lfsr at all times.
- LFSR step: next = {fb, lfsr[WIDTH-1:1]}, fb = XOR-reduce(lfsr & TAPS).
  - Default sequence from 011: 011,001,100,010,101,110,111,011 (period 7).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_load=1 with seed!=0: lfsr<=seed next edge.
  - seed_load=1 with seed==0: lfsr unchanged; seed_err pulses next cycle.
  - start=1 with length!=0: go to RUN; remaining<=length; snapshot<=lfsr; step_cnt<=0; period_valid<=0.
  - start with length==0: ignored.
  - seed_load and start in the same cycle: seed_load wins; start ignored.
- RUN:
  - out_valid=1, busy=1.
  - Handshake on out_valid&out_ready:
    - lfsr advances one step; remaining decrements; step_cnt increments, saturating at all-ones.
    - If the new lfsr equals snapshot and period_valid=0: period<=step_cnt+1; period_valid<=1.
    - If remaining==1 at handshake: go to DONE.
  - Stall (out_ready=0): lfsr and out_value held stable; no counter changes.
  - start and seed_load ignored.
- DONE: done=1 for exactly one cycle, out_valid=0; return to IDLE.
- abort:
  - From RUN: go to IDLE next edge without a done pulse.
  - A handshake in the same cycle still completes (lfsr advances) before abort takes effect.
  - lfsr is retained; period_valid is retained if already set.
  - abort in IDLE/DONE: no effect.
- period_valid stays 0 if the run ends before the sequence returns to snapshot.
- Reset mid-run: immediate return to reset values. No partial handshake is honoured.

Decomposition:
- Package lfsr_ctrl_pkg: FSM state enum (IDLE, RUN, DONE), default TAPS/DEFAULT_SEED constants for the 3-bit configuration.
- Sub-module lfsr_step: purely combinational next-state function (WIDTH, TAPS), reused by future LFSR variants.
- Controller holds the FSM, counters and LFSR register.

Test Plan:
- Reset then start, length=3, out_ready=1 -> out_value 011,001,100 on consecutive cycles; done pulse on the cycle after the third accept; lfsr=010; period_valid=0.
- Reset, start, length=10, out_ready=1 -> 10 words following the default sequence cyclically; period=7 with period_valid=1 after the 7th accept.
- seed_load seed=3'b101, then start length=2 with out_ready toggling 0,1,0,1 -> out_value holds 101 through the stall, then 110; done after the 2nd accept.
- seed_load seed=0 -> seed_err one-cycle pulse; lfsr stays 011.
- start with length=0 -> FSM remains IDLE. start while in RUN -> ignored; the run completes normally.
- Start length=5, accept 2 words, assert abort -> IDLE next cycle; no done pulse; lfsr=100.
- Assert reset mid-run -> outputs return to reset values asynchronously.
